// File: rtl/switch_input_sequencer.sv
// switch_input_sequencer
// Conditions the Minisys enter switch (2-flop sync + debounce), latches the
// operand and case code on each qualified press, and serves them to the CPU
// through a registered two-word MMIO read port.
// Build option: define SW_SIGN_EXT_EN to sign-extend the operand on data reads.
module switch_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int DATA_W          = 16,
    parameter int CASE_W          = 3
) (
    input  logic              Minisys_Clock,
    input  logic              Minisys_Reset_n,
    input  logic [DATA_W-1:0] switch_data,
    input  logic [CASE_W-1:0] switch_case,
    input  logic              switch_enter,
    input  logic              cpu_rd,
    input  logic              cpu_rd_sel,
    output logic [31:0]       cpu_rdata,
    output logic              data_valid,
    output logic              wait_led,
    output logic [CASE_W-1:0] case_led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_WAIT_LOW = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_FULL     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [1:0]        sync_q;
    logic [1:0]        prime_q;
    logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
    logic              enter_db_q, enter_db_d;
    logic              db_prev_q;
    logic [1:0]        state_q, state_d;
    logic              released_q, released_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CASE_W-1:0] case_q, case_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              enter_sync;
    logic              db_rise;
    logic              db_fall;
    logic              consume;
    logic              stat_rd;
    logic [2:0]        case_stat;
    logic [31:0]       status_word;
    logic [31:0]       data_word;

    assign enter_sync = sync_q[1];
    assign db_rise    = enter_db_q & ~db_prev_q;
    assign db_fall    = ~enter_db_q & db_prev_q;
    assign consume    = cpu_rd & cpu_rd_sel;
    assign stat_rd    = cpu_rd & ~cpu_rd_sel;

    assign data_valid = (state_q == S_FULL);
    assign wait_led   = (state_q == S_ARMED);
    assign case_led   = case_q;
    assign cpu_rdata  = rdata_q;

    // Synchronise enter; prime_q marks when the synchroniser holds a real sample
    // so the post-reset low check is not fooled by the cleared flops.
    always_ff @(posedge Minisys_Clock or negedge Minisys_Reset_n) begin
        if (!Minisys_Reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], switch_enter};
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // Debounce: count consecutive cycles the synced level disagrees with enter_db.
    always_comb begin
        db_cnt_d   = '0;
        enter_db_d = enter_db_q;
        if (enter_sync != enter_db_q) begin
            if (db_cnt_q == CNT_LAST) begin
                enter_db_d = enter_sync;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    // Capture/consume state machine with release tracking and sticky overrun.
    always_comb begin
        state_d    = state_q;
        released_d = released_q;
        overrun_d  = overrun_q;
        data_d     = data_q;
        case_d     = case_q;
        if (stat_rd) begin
            overrun_d = 1'b0;
        end
        case (state_q)
            S_WAIT_LOW: begin
                if (prime_q[1] && !enter_sync && !enter_db_q) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (db_rise) begin
                    data_d  = switch_data;
                    case_d  = switch_case;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (db_rise && released_q) begin
                    overrun_d  = 1'b1;
                    released_d = 1'b0;
                end else if (db_fall) begin
                    released_d = 1'b1;
                end
                // The consume read wins over a coincident overrun: leave FULL anyway.
                if (consume) begin
                    state_d    = released_q ? S_ARMED : S_RELEASE;
                    released_d = 1'b0;
                end
            end
            S_RELEASE: begin
                if (!enter_db_q) begin
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_WAIT_LOW;
        endcase
    end

    // Read mux: status word or operand, registered for 1-cycle latency.
    always_comb begin
        case_stat   = 3'(case_q);
        status_word = {24'd0, state_q, enter_db_q, case_stat, overrun_q, data_valid};
`ifdef SW_SIGN_EXT_EN
        data_word   = {{(32-DATA_W){data_q[DATA_W-1]}}, data_q};
`else
        data_word   = 32'(data_q);
`endif
        rdata_d     = rdata_q;
        if (cpu_rd) begin
            rdata_d = cpu_rd_sel ? data_word : status_word;
        end
    end

    // State and datapath registers.
    always_ff @(posedge Minisys_Clock or negedge Minisys_Reset_n) begin
        if (!Minisys_Reset_n) begin
            db_cnt_q   <= '0;
            enter_db_q <= 1'b0;
            db_prev_q  <= 1'b0;
            state_q    <= S_WAIT_LOW;
            released_q <= 1'b0;
            overrun_q  <= 1'b0;
            data_q     <= '0;
            case_q     <= '0;
            rdata_q    <= '0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            enter_db_q <= enter_db_d;
            db_prev_q  <= enter_db_q;
            state_q    <= state_d;
            released_q <= released_d;
            overrun_q  <= overrun_d;
            data_q     <= data_d;
            case_q     <= case_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_switch_input_sequencer.sv
// tb_switch_input_sequencer
// Directed walk through capture, glitch rejection, overrun, sign handling and
// asynchronous reset, followed by random enter/read traffic compared against a
// behavioural model of the sequencer. Honours SW_SIGN_EXT_EN like the design.
module tb_switch_input_sequencer;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] switch_data;
    logic [2:0]  switch_case;
    logic        switch_enter;
    logic        cpu_rd;
    logic        cpu_rd_sel;
    logic [31:0] cpu_rdata;
    logic        data_valid;
    logic        wait_led;
    logic [2:0]  case_led;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    switch_input_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .DATA_W(16),
        .CASE_W(3)
    ) dut (
        .Minisys_Clock(clk),
        .Minisys_Reset_n(rst_n),
        .switch_data(switch_data),
        .switch_case(switch_case),
        .switch_enter(switch_enter),
        .cpu_rd(cpu_rd),
        .cpu_rd_sel(cpu_rd_sel),
        .cpu_rdata(cpu_rdata),
        .data_valid(data_valid),
        .wait_led(wait_led),
        .case_led(case_led)
    );

    // ---------------- behavioural reference model ----------------
    // States by meaning: 0 waiting for low after reset, 1 armed, 2 holding, 3 waiting release.
    logic          m_r1, m_r2, n_r1, n_r2;
    logic [DB-1:0] m_hist, n_hist;
    int            m_hcnt, n_hcnt;
    logic          m_db, m_dbp, n_db, n_dbp;
    int            m_age, n_age;
    logic [1:0]    m_state, n_state;
    logic          m_rel, m_ovr, n_rel, n_ovr;
    logic [15:0]   m_data, n_data;
    logic [2:0]    m_case, n_case;
    logic [31:0]   m_rdata, n_rdata;

    function automatic logic [31:0] ext_word(input logic [15:0] d);
`ifdef SW_SIGN_EXT_EN
        return {{16{d[15]}}, d};
`else
        return {16'd0, d};
`endif
    endfunction

    always_comb begin
        logic rise, fall;
        rise    = m_db && !m_dbp;
        fall    = !m_db && m_dbp;
        n_rdata = m_rdata;
        if (cpu_rd) begin
            n_rdata = cpu_rd_sel ? ext_word(m_data)
                                 : {24'd0, m_state, m_db, m_case, m_ovr, (m_state == 2'd2)};
        end
        n_state = m_state;
        n_rel   = m_rel;
        n_ovr   = (cpu_rd && !cpu_rd_sel) ? 1'b0 : m_ovr;
        n_data  = m_data;
        n_case  = m_case;
        if (m_state == 2'd0) begin
            if (m_age >= 2 && !m_r2 && !m_db) n_state = 2'd1;
        end else if (m_state == 2'd1) begin
            if (rise) begin
                n_data  = switch_data;
                n_case  = switch_case;
                n_state = 2'd2;
            end
        end else if (m_state == 2'd2) begin
            if (rise && m_rel) begin
                n_ovr = 1'b1;
                n_rel = 1'b0;
            end else if (fall) begin
                n_rel = 1'b1;
            end
            if (cpu_rd && cpu_rd_sel) begin
                n_state = m_rel ? 2'd1 : 2'd3;
                n_rel   = 1'b0;
            end
        end else begin
            if (!m_db) n_state = 2'd1;
        end
        // Debounced level flips once the last DB synced samples all disagree with it.
        n_hist = {m_hist[DB-2:0], m_r2};
        n_hcnt = (m_hcnt < DB) ? m_hcnt + 1 : m_hcnt;
        n_dbp  = m_db;
        n_db   = m_db;
        if (n_hcnt == DB && n_hist == {DB{~m_db}}) n_db = ~m_db;
        n_r1   = switch_enter;
        n_r2   = m_r1;
        n_age  = (m_age < 2) ? m_age + 1 : m_age;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r1 <= 1'b0; m_r2 <= 1'b0; m_hist <= '0; m_hcnt <= 0;
            m_db <= 1'b0; m_dbp <= 1'b0; m_age <= 0; m_state <= 2'd0;
            m_rel <= 1'b0; m_ovr <= 1'b0; m_data <= '0; m_case <= '0; m_rdata <= '0;
        end else begin
            m_r1 <= n_r1; m_r2 <= n_r2; m_hist <= n_hist; m_hcnt <= n_hcnt;
            m_db <= n_db; m_dbp <= n_dbp; m_age <= n_age; m_state <= n_state;
            m_rel <= n_rel; m_ovr <= n_ovr; m_data <= n_data; m_case <= n_case;
            m_rdata <= n_rdata;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic sel);
        cpu_rd     = 1'b1;
        cpu_rd_sel = sel;
        @(negedge clk);
        cpu_rd     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        rst_n = 1'b0; switch_data = '0; switch_case = '0; switch_enter = 1'b0;
        cpu_rd = 1'b0; cpu_rd_sel = 1'b0;

        // Reset state, then arm with enter low
        cyc(10);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_wait", {31'd0, wait_led}, 32'd0);
        check("rst_case", {29'd0, case_led}, 32'd0);
        rst_n = 1'b1;
        cyc(3);
        check("armed_wait", {31'd0, wait_led}, 32'd1);
        rd(1'b0);
        check("armed_status", cpu_rdata, 32'h40);

        // Basic capture and latency
        switch_data = 16'h0001; switch_case = 3'd0; switch_enter = 1'b1;
        cyc(6);
        check("lat_before", {31'd0, data_valid}, 32'd0);
        cyc(1);
        check("lat_at", {31'd0, data_valid}, 32'd1);
        check("full_wait", {31'd0, wait_led}, 32'd0);
        rd(1'b0);
        check("full_status", cpu_rdata, 32'hA1);
        rd(1'b1);
        check("data1", cpu_rdata, 32'h1);
        check("consumed", {31'd0, data_valid}, 32'd0);
        switch_enter = 1'b0;
        cyc(8);
        check("rearm", {31'd0, wait_led}, 32'd1);

        // Short glitch is rejected
        switch_enter = 1'b1;
        cyc(3);
        switch_enter = 1'b0;
        cyc(10);
        check("glitch_valid", {31'd0, data_valid}, 32'd0);
        rd(1'b0);
        check("glitch_status", cpu_rdata, 32'h40);

        // Overrun: release and re-press while holding
        switch_data = 16'h1234; switch_case = 3'd5; switch_enter = 1'b1;
        cyc(8);
        check("ovr_full", {31'd0, data_valid}, 32'd1);
        check("ovr_case", {29'd0, case_led}, 32'd5);
        switch_enter = 1'b0;
        cyc(8);
        switch_data = 16'h00AB; switch_enter = 1'b1;
        cyc(8);
        rd(1'b0);
        check("ovr_stat1", cpu_rdata, 32'hB7);
        rd(1'b0);
        check("ovr_stat2", cpu_rdata, 32'hB5);
        rd(1'b1);
        check("ovr_data", cpu_rdata, 32'h1234);
        check("ovr_consumed", {31'd0, data_valid}, 32'd0);
        switch_enter = 1'b0;
        cyc(8);
        check("ovr_rearm", {31'd0, wait_led}, 32'd1);

        // Negative operand
        switch_data = 16'h8001; switch_case = 3'd2; switch_enter = 1'b1;
        cyc(8);
        rd(1'b1);
`ifdef SW_SIGN_EXT_EN
        check("neg_data", cpu_rdata, 32'hFFFF8001);
`else
        check("neg_data", cpu_rdata, 32'h00008001);
`endif
        switch_enter = 1'b0;
        cyc(8);
        check("neg_rearm", {31'd0, wait_led}, 32'd1);

        // Asynchronous reset mid-debounce
        switch_enter = 1'b1;
        cyc(3);
        #1 rst_n = 1'b0;
        #1;
        check("arst1_wait", {31'd0, wait_led}, 32'd0);
        check("arst1_case", {29'd0, case_led}, 32'd0);
        check("arst1_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        check("hold_high_wait", {31'd0, wait_led}, 32'd0);
        check("hold_high_valid", {31'd0, data_valid}, 32'd0);
        rd(1'b0);
        check("hold_high_status", cpu_rdata, 32'h20);
        switch_enter = 1'b0;
        cyc(10);
        check("low_arms", {31'd0, wait_led}, 32'd1);

        // Asynchronous reset while holding data
        switch_data = 16'h5A5A; switch_case = 3'd7; switch_enter = 1'b1;
        cyc(8);
        check("full2_valid", {31'd0, data_valid}, 32'd1);
        rd(1'b0);
        check("full2_status", cpu_rdata, 32'hBD);
        #1 rst_n = 1'b0;
        #1;
        check("arst2_valid", {31'd0, data_valid}, 32'd0);
        check("arst2_case", {29'd0, case_led}, 32'd0);
        check("arst2_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(12);
        check("arst2_stay", {31'd0, wait_led}, 32'd0);
        switch_enter = 1'b0;
        cyc(10);
        check("arst2_rearm", {31'd0, wait_led}, 32'd1);

        // Random traffic against the model
        hold = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            check("rnd_rdata", cpu_rdata, m_rdata);
            check("rnd_valid", {31'd0, data_valid}, {31'd0, (m_state == 2'd2)});
            check("rnd_wait", {31'd0, wait_led}, {31'd0, (m_state == 2'd1)});
            check("rnd_case", {29'd0, case_led}, {29'd0, m_case});
            cpu_rd     = ($urandom_range(0, 3) == 0);
            cpu_rd_sel = 1'($urandom_range(0, 1));
            if (hold == 0) begin
                switch_enter = ~switch_enter;
                hold = $urandom_range(1, 12);
                if (!switch_enter) begin
                    switch_data = 16'($urandom);
                    switch_case = 3'($urandom);
                end
            end else begin
                hold--;
            end
        end
        cpu_rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
